edge_fragment_generator: RTL and testbench

//  Parametrised successor fragment generator for the rasterizer back end.

---
 rtl/edge_fragment_generator.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_edge_fragment_generator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_fragment_generator.sv
// ----------------------------------------------------------------------------
// edge_fragment_generator
//
// Purpose:
//   Scans a triangle bounding box [xmin,xmax) x [ymin,ymax) one pixel per
//   cycle in raster order. It evaluates three edge functions incrementally and
//   pushes every inside pixel into an internal FIFO. The FIFO feeds the
//   shader/depth stage through a valid/pop handshake.
//
// Configuration:
//   FRAG_GEN_TOP_LEFT_EN  - when defined, w_i == 0 counts as inside only for
//                           top-left edges (ey_i < 0, or ey_i == 0 and
//                           ex_i > 0). When undefined, w_i >= 0 is inside for
//                           every edge.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 launch traversal (sampled only in idle)
//   i_xmin/i_xmax           x range [xmin,xmax), unsigned
//   i_ymin/i_ymax           y range [ymin,ymax), unsigned
//   i_ex0..2 / i_ey0..2     per-edge increments for x+1 / y+1
//   i_w0..2                 edge values at (xmin,ymin)
//   i_pop_frag              consumer takes the head fragment
//   o_frag_val              FIFO non-empty
//   o_frag_x/o_frag_y/o_frag_w  head fragment; o_frag_w = {w2,w1,w0}
//   o_busy                  traversal or drain in progress
//   o_done                  one-cycle pulse when a triangle completes
//   o_frag_cnt              saturating count of fragments for this triangle
// ----------------------------------------------------------------------------
module edge_fragment_generator #(
  parameter int unsigned COORD_W       = 16,
  parameter int unsigned EDGE_W        = 32,
  parameter int unsigned LG_FIFO_DEPTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [COORD_W-1:0]    i_xmin,
  input  logic [COORD_W-1:0]    i_xmax,
  input  logic [COORD_W-1:0]    i_ymin,
  input  logic [COORD_W-1:0]    i_ymax,
  input  logic [EDGE_W-1:0]     i_ex0,
  input  logic [EDGE_W-1:0]     i_ex1,
  input  logic [EDGE_W-1:0]     i_ex2,
  input  logic [EDGE_W-1:0]     i_ey0,
  input  logic [EDGE_W-1:0]     i_ey1,
  input  logic [EDGE_W-1:0]     i_ey2,
  input  logic [EDGE_W-1:0]     i_w0,
  input  logic [EDGE_W-1:0]     i_w1,
  input  logic [EDGE_W-1:0]     i_w2,
  input  logic                  i_pop_frag,
  output logic                  o_frag_val,
  output logic [COORD_W-1:0]    o_frag_x,
  output logic [COORD_W-1:0]    o_frag_y,
  output logic [3*EDGE_W-1:0]   o_frag_w,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_frag_cnt
);

  localparam int unsigned Depth  = 1 << LG_FIFO_DEPTH;
  localparam int unsigned PtrW   = LG_FIFO_DEPTH + 1;
  localparam int unsigned EntryW = 2 * COORD_W + 3 * EDGE_W;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               r_state;
  logic                 r_done;
  logic [15:0]          r_frag_cnt;

  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic [COORD_W-1:0]   r_xmin;
  logic [COORD_W-1:0]   r_xmax;
  logic [COORD_W-1:0]   r_ymax;

  logic [EDGE_W-1:0]    r_ex     [3];
  logic [EDGE_W-1:0]    r_ey     [3];
  logic [EDGE_W-1:0]    r_row_w  [3];
  logic [EDGE_W-1:0]    r_cur_w  [3];

  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [EntryW-1:0]    r_mem    [Depth];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_e               w_state_nxt;
  logic                 w_done_nxt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_advance;
  logic                 w_start;
  logic                 w_empty_bbox;
  logic [2:0]           w_edge_in;
  logic                 w_inside;
  logic [COORD_W:0]     w_x_inc;
  logic [COORD_W:0]     w_y_inc;
  logic                 w_x_more;
  logic                 w_y_more;
  logic [EDGE_W-1:0]    w_in_ex  [3];
  logic [EDGE_W-1:0]    w_in_ey  [3];
  logic [EDGE_W-1:0]    w_in_w   [3];
  logic [EntryW-1:0]    w_head;

  assign w_in_ex[0] = i_ex0;
  assign w_in_ex[1] = i_ex1;
  assign w_in_ex[2] = i_ex2;
  assign w_in_ey[0] = i_ey0;
  assign w_in_ey[1] = i_ey1;
  assign w_in_ey[2] = i_ey2;
  assign w_in_w[0]  = i_w0;
  assign w_in_w[1]  = i_w1;
  assign w_in_w[2]  = i_w2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                   (r_wr_ptr[LG_FIFO_DEPTH-1:0] == r_rd_ptr[LG_FIFO_DEPTH-1:0]);

  // One bit wider so xmax/ymax at the top of the coordinate range still work.
  assign w_x_inc  = {1'b0, r_x} + (COORD_W + 1)'(1);
  assign w_y_inc  = {1'b0, r_y} + (COORD_W + 1)'(1);
  assign w_x_more = (w_x_inc < {1'b0, r_xmax});
  assign w_y_more = (w_y_inc < {1'b0, r_ymax});

  // Inside test uses sign bits directly: all edge arithmetic is modular.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
`ifdef FRAG_GEN_TOP_LEFT_EN
      w_edge_in[i] = (!r_cur_w[i][EDGE_W-1] && (r_cur_w[i] != '0)) ||
                     ((r_cur_w[i] == '0) &&
                      (r_ey[i][EDGE_W-1] ||
                       ((r_ey[i] == '0) && !r_ex[i][EDGE_W-1] && (r_ex[i] != '0))));
`else
      w_edge_in[i] = !r_cur_w[i][EDGE_W-1];
`endif
    end
  end

  assign w_inside     = &w_edge_in;
  assign w_start      = (r_state == StIdle) && i_start;
  assign w_empty_bbox = (i_xmin >= i_xmax) || (i_ymin >= i_ymax);

  // A blocked pixel holds the scan; full uses registered pointers only, so a
  // pop in the same cycle does not let the pixel through until next cycle.
  assign w_push    = (r_state == StScan) && w_inside && !w_full;
  assign w_advance = (r_state == StScan) && !(w_inside && w_full);
  assign w_pop     = i_pop_frag && !w_empty;

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = w_empty_bbox ? StDrain : StScan;
        end
      end
      StScan: begin
        if (w_advance && !w_x_more && !w_y_more) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Scan datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_frag_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        r_ex[i]    <= '0;
        r_ey[i]    <= '0;
        r_row_w[i] <= '0;
        r_cur_w[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_x        <= i_xmin;
        r_y        <= i_ymin;
        r_xmin     <= i_xmin;
        r_xmax     <= i_xmax;
        r_ymax     <= i_ymax;
        r_frag_cnt <= '0;
        for (int i = 0; i < 3; i++) begin
          r_ex[i]    <= w_in_ex[i];
          r_ey[i]    <= w_in_ey[i];
          r_row_w[i] <= w_in_w[i];
          r_cur_w[i] <= w_in_w[i];
        end
      end else if (w_advance) begin
        if (w_x_more) begin
          r_x <= w_x_inc[COORD_W-1:0];
          for (int i = 0; i < 3; i++) begin
            r_cur_w[i] <= r_cur_w[i] + r_ex[i];
          end
        end else begin
          // Next row restarts from the row-start value, not the row end.
          r_x <= r_xmin;
          r_y <= w_y_inc[COORD_W-1:0];
          for (int i = 0; i < 3; i++) begin
            r_row_w[i] <= r_row_w[i] + r_ey[i];
            r_cur_w[i] <= r_row_w[i] + r_ey[i];
          end
        end
      end

      if (w_push && (r_frag_cnt != 16'hFFFF)) begin
        r_frag_cnt <= r_frag_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[LG_FIFO_DEPTH-1:0]] <= {r_x, r_y, r_cur_w[2], r_cur_w[1], r_cur_w[0]};
    end
  end

  assign w_head = r_mem[r_rd_ptr[LG_FIFO_DEPTH-1:0]];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_frag_val = !w_empty;
    o_frag_x   = '0;
    o_frag_y   = '0;
    o_frag_w   = '0;
    if (!w_empty) begin
      o_frag_x = w_head[EntryW-1 -: COORD_W];
      o_frag_y = w_head[3*EDGE_W +: COORD_W];
      o_frag_w = w_head[3*EDGE_W-1:0];
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_frag_cnt = r_frag_cnt;

endmodule

// File: tb/tb_edge_fragment_generator.sv
// ----------------------------------------------------------------------------
// tb_edge_fragment_generator
//
// Purpose:
//   Directed bench for edge_fragment_generator with a 4-entry output FIFO.
//   Each triangle's expected fragments come from a closed-form model
//   (w = w0 + dx*ex + dy*ey). They are queued at launch and matched in order
//   against the DUT head fragment whenever a pop occurs.
// ----------------------------------------------------------------------------
module tb_edge_fragment_generator;

  localparam int unsigned CW = 16;
  localparam int unsigned EW = 32;
  localparam int unsigned LG = 2;

`ifdef FRAG_GEN_TOP_LEFT_EN
  localparam bit TlEn = 1'b1;
`else
  localparam bit TlEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            pop;
  logic [CW-1:0]   xmin, xmax, ymin, ymax;
  logic [EW-1:0]   ex [3];
  logic [EW-1:0]   ey [3];
  logic [EW-1:0]   w  [3];
  logic            frag_val;
  logic [CW-1:0]   frag_x, frag_y;
  logic [3*EW-1:0] frag_w;
  logic            busy, done;
  logic [15:0]     frag_cnt;

  int              checks = 0;
  int              errors = 0;
  int              done_cnt = 0;
  int              nfrag = 0;
  bit              rnd_pop = 1'b0;
  logic [127:0]    exp_q [$];

  always #5 clk = ~clk;

  edge_fragment_generator #(
    .COORD_W       (CW),
    .EDGE_W        (EW),
    .LG_FIFO_DEPTH (LG)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_xmin     (xmin),
    .i_xmax     (xmax),
    .i_ymin     (ymin),
    .i_ymax     (ymax),
    .i_ex0      (ex[0]),
    .i_ex1      (ex[1]),
    .i_ex2      (ex[2]),
    .i_ey0      (ey[0]),
    .i_ey1      (ey[1]),
    .i_ey2      (ey[2]),
    .i_w0       (w[0]),
    .i_w1       (w[1]),
    .i_w2       (w[2]),
    .i_pop_frag (pop),
    .o_frag_val (frag_val),
    .o_frag_x   (frag_x),
    .o_frag_y   (frag_y),
    .o_frag_w   (frag_w),
    .o_busy     (busy),
    .o_done     (done),
    .o_frag_cnt (frag_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit edge_in(input logic [31:0] wv, input logic [31:0] exv,
                                 input logic [31:0] eyv);
    bit tl;
    tl = ($signed(eyv) < 0) || ((eyv == 0) && ($signed(exv) > 0));
    if ($signed(wv) > 0) return 1'b1;
    if (wv == 0) return TlEn ? tl : 1'b1;
    return 1'b0;
  endfunction

  // Closed-form model of the raster walk; queues expected fragments.
  task automatic load_model(output int n);
    logic [31:0] dx, dy;
    logic [31:0] wv [3];
    bit          in_all;
    n = 0;
    for (int yy = int'(ymin); yy < int'(ymax); yy++) begin
      for (int xx = int'(xmin); xx < int'(xmax); xx++) begin
        dx = 32'(xx - int'(xmin));
        dy = 32'(yy - int'(ymin));
        in_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
          wv[i] = w[i] + dx * ex[i] + dy * ey[i];
          if (!edge_in(wv[i], ex[i], ey[i])) in_all = 1'b0;
        end
        if (in_all) begin
          exp_q.push_back({16'(xx), 16'(yy), wv[2], wv[1], wv[0]});
          n++;
        end
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst) begin
      if (done) done_cnt++;
      if (frag_val && pop) begin
        nfrag++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL frag_extra observed=%0h expected=none", {frag_x, frag_y, frag_w});
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frag", {frag_x, frag_y, frag_w}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_pop) pop = 1'($urandom_range(0, 1));
  endtask

  task automatic set_edges(input logic [31:0] wv, input logic [31:0] exv,
                           input logic [31:0] eyv);
    for (int i = 0; i < 3; i++) begin
      w[i]  = wv;
      ex[i] = exv;
      ey[i] = eyv;
    end
  endtask

  task automatic set_bbox(input int x0, input int x1, input int y0, input int y1);
    xmin = 16'(x0);
    xmax = 16'(x1);
    ymin = 16'(y0);
    ymax = 16'(y1);
  endtask

  // Leaves the bench 1 time unit after the edge that samples start.
  task automatic launch(output int n);
    load_model(n);
    done_cnt = 0;
    nfrag    = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic finish_tri(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin
      tick();
      k++;
    end
    rnd_pop = 1'b0;
    pop     = 1'b1;
    repeat (4) tick();
    chk({tag, "_done_pulses"}, 128'(done_cnt), 128'(1));
    chk({tag, "_frag_cnt"}, 128'(frag_cnt), 128'(n));
    chk({tag, "_frags_seen"}, 128'(nfrag), 128'(n));
    chk({tag, "_leftover"}, 128'(exp_q.size()), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    pop   = 1'b0;
    set_bbox(0, 0, 0, 0);
    set_edges(32'd0, 32'd0, 32'd0);
    repeat (3) tick();

    // Reset state
    chk("rst_frag_val", 128'(frag_val), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_frag_cnt", 128'(frag_cnt), 128'(0));
    chk("rst_frag_data", {frag_x, frag_y, frag_w}, 128'(0));
    rst = 1'b0;
    tick();

    // Abort a traversal that is stalled on a full FIFO
    set_bbox(0, 4, 0, 4);
    set_edges(32'd0, 32'd1, 32'd1);
    pop = 1'b0;
    launch(n);
    repeat (8) tick();
    chk("stall_busy", 128'(busy), 128'(1));
    chk("stall_frag_cnt", 128'(frag_cnt), 128'(4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    chk("abort_frag_val", 128'(frag_val), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_frag_cnt", 128'(frag_cnt), 128'(0));
    repeat (3) tick();
    chk("abort_no_done", 128'(done_cnt), 128'(0));

    // 1x1 after abort: only the new fragment may come out
    set_bbox(0, 1, 0, 1);
    pop = 1'b1;
    launch(n);
    finish_tri("after_rst_1x1", n, 50);
    chk("after_rst_cnt1", 128'(frag_cnt), 128'(1));

    // Raster order 4x2, all inside, consumer always ready; latency check
    set_bbox(0, 4, 0, 2);
    set_edges(32'd0, 32'd1, 32'd1);
    pop = 1'b1;
    launch(n);
    @(negedge clk);
    chk("lat_t1_frag_val", 128'(frag_val), 128'(0));
    @(negedge clk);
    chk("lat_t2_frag_val", 128'(frag_val), 128'(1));
    finish_tri("raster", n, 100);
    chk("raster_cnt8", 128'(frag_cnt), 128'(8));

    // Column x=0 rejected by edge 0
    w[0]  = 32'hFFFF_FFFF;
    ex[0] = 32'd1;
    ey[0] = 32'd0;
    launch(n);
    finish_tri("reject_x0", n, 100);
    chk("reject_x0_cnt6", 128'(frag_cnt), 128'(6));

    // FIFO fills to depth and the scan holds
    set_edges(32'd0, 32'd1, 32'd1);
    pop = 1'b0;
    launch(n);
    repeat (20) tick();
    chk("full_frag_cnt", 128'(frag_cnt), 128'(4));
    chk("full_busy", 128'(busy), 128'(1));
    chk("full_frag_val", 128'(frag_val), 128'(1));
    chk("full_no_done", 128'(done_cnt), 128'(0));
    pop = 1'b1;
    finish_tri("full_drain", n, 100);

    // Empty bbox: done two cycles after start, no fragments
    set_bbox(5, 5, 0, 3);
    launch(n);
    @(negedge clk);
    chk("empty_t1_done", 128'(done), 128'(0));
    chk("empty_t1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("empty_t2_done", 128'(done), 128'(1));
    finish_tri("empty_bbox", n, 20);

    // Fill rule on w0 == 0
    set_bbox(0, 1, 0, 1);
    set_edges(32'd5, 32'd1, 32'd1);
    w[0]  = 32'd0;
    ex[0] = 32'd1;
    ey[0] = 32'd0;
    launch(n);
    finish_tri("tl_pos", n, 20);
    chk("tl_pos_cnt", 128'(frag_cnt), 128'(1));
    ex[0] = 32'hFFFF_FFFF;
    launch(n);
    finish_tri("tl_neg", n, 20);
    chk("tl_neg_cnt", 128'(frag_cnt), TlEn ? 128'(0) : 128'(1));

    // Mixed-sign edges with random consumer backpressure
    set_bbox(3, 8, 10, 14);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3; i++) begin
        w[i]  = 32'($urandom_range(0, 60)) - 32'd30;
        ex[i] = 32'($urandom_range(0, 12)) - 32'd6;
        ey[i] = 32'($urandom_range(0, 12)) - 32'd6;
      end
      rnd_pop = 1'b1;
      launch(n);
      finish_tri("random", n, 400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
